// File: rtl/barrido_comparador_if.sv
// barrido_comparador_if: control/result bundle between the sweep engine,
// the control FSM (start/cancelar) and the external equality comparator
// (iguales/candidato).
interface barrido_comparador_if #(
    parameter int unsigned n = 5
);
    logic         start;
    logic         cancelar;
    logic         iguales;
    logic [n-1:0] candidato;
    logic         busy;
    logic         done;
    logic         hit;
    logic [n-1:0] valor;

    modport master (
        output start, cancelar, iguales,
        input  candidato, busy, done, hit, valor
    );

    modport slave (
        input  start, cancelar, iguales,
        output candidato, busy, done, hit, valor
    );
endinterface

// File: rtl/barrido_comparador.sv
// barrido_comparador: sweeps candidato from 0 upward against an external
// equality comparator and reports the first match (hit/valor) or a miss.
// Optional macro BARRIDO_SETTLE_EN: holds each candidate one extra cycle
// (PRESENT -> CHECK) before sampling iguales, for a registered comparator.
module barrido_comparador #(
    parameter int unsigned n = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    barrido_comparador_if.slave  bus
);
    localparam int unsigned W = n;
    localparam logic [W-1:0] CAND_MAX = {W{1'b1}};

`ifdef BARRIDO_SETTLE_EN
    typedef enum logic [1:0] {IDLE, PRESENT, CHECK, FIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, PRESENT, FIN} state_t;
`endif

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_cand;
    logic [W-1:0]   w_cand_nxt;
    logic           r_busy;
    logic           w_busy_nxt;
    logic           r_done;
    logic           w_done_nxt;
    logic           r_hit;
    logic           w_hit_nxt;
    logic [W-1:0]   r_valor;
    logic [W-1:0]   w_valor_nxt;
    logic           w_active;
    logic           w_sample;

    // State and output registers; every output is registered and resets to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cand  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hit   <= 1'b0;
            r_valor <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cand  <= w_cand_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_hit   <= w_hit_nxt;
            r_valor <= w_valor_nxt;
        end
    end

    // Next state and next output values; cancel beats any simultaneous match.
    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_hit_nxt   = r_hit;
        w_valor_nxt = r_valor;
        w_active    = 1'b0;
        w_sample    = 1'b0;

        case (r_state)
            IDLE: begin
                w_cand_nxt = '0;
                w_busy_nxt = 1'b0;
                if (bus.start && !bus.cancelar) begin
                    w_state_nxt = PRESENT;
                    w_busy_nxt  = 1'b1;
                    w_hit_nxt   = 1'b0;
                    w_valor_nxt = '0;
                end
            end
            PRESENT: begin
                w_active = 1'b1;
`ifdef BARRIDO_SETTLE_EN
                w_state_nxt = CHECK;
`else
                w_sample = 1'b1;
`endif
            end
`ifdef BARRIDO_SETTLE_EN
            CHECK: begin
                w_active = 1'b1;
                w_sample = 1'b1;
            end
`endif
            FIN: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
                w_cand_nxt  = '0;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_active && bus.cancelar) begin
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
            w_cand_nxt  = '0;
            w_hit_nxt   = 1'b0;
            w_valor_nxt = '0;
        end else if (w_sample) begin
            if (bus.iguales) begin
                w_state_nxt = FIN;
                w_done_nxt  = 1'b1;
                w_hit_nxt   = 1'b1;
                w_valor_nxt = r_cand;
                w_cand_nxt  = '0;
            end else if (r_cand == CAND_MAX) begin
                w_state_nxt = FIN;
                w_done_nxt  = 1'b1;
                w_hit_nxt   = 1'b0;
                w_valor_nxt = '0;
                w_cand_nxt  = '0;
            end else begin
                w_cand_nxt = r_cand + W'(1);
`ifdef BARRIDO_SETTLE_EN
                w_state_nxt = PRESENT;
`endif
            end
        end
    end

    assign bus.candidato = r_cand;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.hit       = r_hit;
    assign bus.valor     = r_valor;
endmodule

// File: tb/tb_barrido_comparador.sv
// tb_barrido_comparador: directed and randomized sweeps checked every cycle
// against a behavioural model of the candidate sweep, plus literal checks.
module tb_barrido_comparador;
    localparam int unsigned N    = 5;
    localparam int          VMAX = (1 << N) - 1;
`ifdef BARRIDO_SETTLE_EN
    localparam bit SETTLE = 1'b1;
`else
    localparam bit SETTLE = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   secret;
    bit   force_miss;
    bit   chk_en;
    int   tests;
    int   fails;

    barrido_comparador_if #(.n(N)) bus ();

    barrido_comparador #(.n(N)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational external comparator: A = secret, B = candidato.
    assign bus.iguales = !force_miss && (int'(bus.candidato) == secret);

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: m_t counts edges since the accepting edge; candidate = t or t/2.
    int m_phase;  // 0 idle, 1 sweeping, 2 done-cycle
    int m_t;
    int m_hit;
    int m_valor;

    function automatic int cand_of(input int t);
        return SETTLE ? (t / 2) : t;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_t = 0; m_hit = 0; m_valor = 0;
        end else begin
            case (m_phase)
                0: if (bus.start && !bus.cancelar) begin
                    m_phase = 1; m_t = 0; m_hit = 0; m_valor = 0;
                end
                1: begin
                    int  k;
                    bit  smp;
                    k   = cand_of(m_t);
                    smp = !SETTLE || (m_t % 2 == 1);
                    if (bus.cancelar) begin
                        m_phase = 0; m_hit = 0; m_valor = 0;
                    end else if (smp && !force_miss && k == secret) begin
                        m_phase = 2; m_hit = 1; m_valor = k;
                    end else if (smp && k == VMAX) begin
                        m_phase = 2; m_hit = 0; m_valor = 0;
                    end else begin
                        m_t = m_t + 1;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Per-cycle compare of all outputs against the model.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("cyc_candidato", int'(bus.candidato), (m_phase == 1) ? cand_of(m_t) : 0);
            check("cyc_busy",      int'(bus.busy),      (m_phase != 0) ? 1 : 0);
            check("cyc_done",      int'(bus.done),      (m_phase == 2) ? 1 : 0);
            check("cyc_hit",       int'(bus.hit),       m_hit);
            check("cyc_valor",     int'(bus.valor),     m_valor);
        end
    end

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (bus.done) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_cand(input int v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.busy && int'(bus.candidato) == v) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic directed_sweep(input string name, input int sec, input bit miss,
                                  input int exp_cyc, input int exp_hit, input int exp_valor);
        int cyc;
        bit ok;
        secret     = sec;
        force_miss = miss;
        pulse_start();
        wait_done(cyc, ok);
        check({name, "_done_seen"}, int'(ok), 1);
        check({name, "_done_cycle"}, cyc, exp_cyc);
        check({name, "_hit"}, int'(bus.hit), exp_hit);
        check({name, "_valor"}, int'(bus.valor), exp_valor);
        @(negedge clk);
        check({name, "_busy_after"}, int'(bus.busy), 0);
        check({name, "_done_after"}, int'(bus.done), 0);
        force_miss = 1'b0;
    endtask

    initial begin
        bit ok;
        int cyc;
        tests = 0; fails = 0; chk_en = 1'b0;
        secret = 0; force_miss = 1'b0;
        bus.start = 1'b0; bus.cancelar = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Reset then idle for 10 cycles with no start.
        secret = 3;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_all_zero",
                  int'({bus.candidato, bus.busy, bus.done, bus.hit, bus.valor}), 0);
        end

        // Match at 13, miss, match at 0.
        directed_sweep("match13", 13, 1'b0, SETTLE ? 28 : 14, 1, 13);
        directed_sweep("miss", 5, 1'b1, SETTLE ? 64 : 32, 0, 0);
        directed_sweep("match0", 0, 1'b0, SETTLE ? 2 : 1, 1, 0);
        directed_sweep("match31", 31, 1'b0, SETTLE ? 64 : 32, 1, 31);

        // Cancel at candidato 7 while iguales is high.
        secret = 7;
        pulse_start();
        wait_cand(7, ok);
        check("cancel_reach7", int'(ok), 1);
        check("cancel_iguales", int'(bus.iguales), 1);
        bus.cancelar = 1'b1;
        @(negedge clk);
        bus.cancelar = 1'b0;
        check("cancel_busy", int'(bus.busy), 0);
        check("cancel_done", int'(bus.done), 0);
        check("cancel_hit", int'(bus.hit), 0);
        repeat (3) begin
            @(negedge clk);
            check("cancel_no_done", int'(bus.done), 0);
        end

        // Second start at candidato 4 must not restart the count.
        secret = 20;
        pulse_start();
        wait_cand(4, ok);
        check("busy_reach4", int'(ok), 1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_start_ignored", int'(bus.candidato), SETTLE ? 4 : 5);
        wait_done(cyc, ok);
        check("busy_done_seen", int'(ok), 1);
        check("busy_valor", int'(bus.valor), 20);
        @(negedge clk);

        // Asynchronous reset mid-sweep at candidato 9.
        secret = 25;
        pulse_start();
        wait_cand(9, ok);
        check("rst_reach9", int'(ok), 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_zero",
              int'({bus.candidato, bus.busy, bus.done, bus.hit, bus.valor}), 0);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_stays_idle", int'(bus.busy), 0);

        // Start together with cancelar in idle is not accepted.
        bus.cancelar = 1'b1;
        pulse_start();
        bus.cancelar = 1'b0;
        check("start_cancel_idle", int'(bus.busy), 0);

        // Randomized sweeps with start noise and occasional cancels.
        for (int s = 0; s < 30; s++) begin
            secret     = int'($urandom_range(0, VMAX));
            force_miss = ($urandom_range(0, 7) == 0);
            pulse_start();
            for (int c = 0; c < 200 && m_phase != 0; c++) begin
                bus.start    = ($urandom_range(0, 9) == 0);
                bus.cancelar = ($urandom_range(0, 79) == 0);
                @(negedge clk);
            end
            bus.start    = 1'b0;
            bus.cancelar = 1'b0;
            check("rand_ended_idle", m_phase, 0);
            repeat (int'($urandom_range(1, 3))) @(negedge clk);
        end
        force_miss = 1'b0;

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
